// File: rtl/copy_responder_if.sv
// copy_responder_if: ring, engine request and engine reply signals of the copy responder.
interface copy_responder_if;
    logic [31:0] RingIn;
    logic [3:0]  SlotTypeIn;
    logic [3:0]  SourceIn;
    logic [31:0] respRingOut;
    logic [3:0]  respSlotTypeOut;
    logic [3:0]  respSourceOut;
    logic        respDriveRing;
    logic        respWantsToken;
    logic        respAcquireToken;
    logic        respTake;
    logic [31:0] reqData;
    logic        reqEmpty;
    logic        reqRead;
    logic        replyValid;
    logic        replyReady;
    logic [3:0]  replyDest;
    logic [3:0]  replyType;
    logic [31:0] replyData;
    logic [7:0]  dropCount;

    modport slave (
        input  RingIn, SlotTypeIn, SourceIn, respAcquireToken, reqRead,
        input  replyValid, replyDest, replyType, replyData,
        output respRingOut, respSlotTypeOut, respSourceOut, respDriveRing,
        output respWantsToken, respTake, reqData, reqEmpty, replyReady, dropCount
    );

    modport master (
        output RingIn, SlotTypeIn, SourceIn, respAcquireToken, reqRead,
        output replyValid, replyDest, replyType, replyData,
        input  respRingOut, respSlotTypeOut, respSourceOut, respDriveRing,
        input  respWantsToken, respTake, reqData, reqEmpty, replyReady, dropCount
    );
endinterface

// File: rtl/copy_responder.sv
// copy_responder: captures ring requests addressed to this core into a FWFT FIFO and sends engine replies.
// Optional macro COPY_RESP_DROPCNT_EN enables the saturating dropped-request counter.
module copy_responder #(
    parameter int RQ_DEPTH = 32
) (
    input logic             clock,
    input logic             reset,
    input logic [3:0]       whichCore,
    copy_responder_if.slave bus
);
    localparam int AW = $clog2(RQ_DEPTH);
    localparam int CW = AW + 1;

    typedef enum logic [1:0] {IDLE, WAIT_TOKEN, SEND} state_t;

    state_t        state, state_next;
    logic [5:0]    in_len;
    logic          rx_req, rx_keep;
    logic          is_hdr, is_req, accept, wr, pop;
    logic [31:0]   mem [RQ_DEPTH];
    logic [AW-1:0] wptr, rptr;
    logic [CW-1:0] cnt, free;
    logic [3:0]    dest_q, type_q;
    logic [31:0]   data_q, ring_out;
    logic          drive, wants, ready;
    logic          unused_src;

    assign unused_src = ^bus.SourceIn;

    assign is_hdr = !reset && in_len == 6'd0 && bus.SlotTypeIn == 4'd8;
    assign is_req = is_hdr && bus.RingIn[17:14] == whichCore;
    assign free   = CW'(RQ_DEPTH) - cnt;
    assign accept = 32'(free) >= 32'(bus.RingIn[5:0]) + 32'd1;
    assign wr     = (is_req && accept) || (rx_req && rx_keep);
    assign pop    = bus.reqRead && cnt != '0;

    // inLen follows every message on the ring; rx_req marks payload cycles of our own requests
    always_ff @(posedge clock) begin
        if (reset) begin
            in_len  <= '0;
            rx_req  <= 1'b0;
            rx_keep <= 1'b0;
        end else begin
            in_len <= is_hdr ? bus.RingIn[5:0] : (in_len != 6'd0 ? in_len - 6'd1 : in_len);
            if (is_req) begin
                rx_req  <= bus.RingIn[5:0] != 6'd0;
                rx_keep <= accept;
            end else if (in_len == 6'd1) begin
                rx_req <= 1'b0;
            end
        end
    end

    always_ff @(posedge clock) begin
        if (wr) mem[wptr] <= bus.RingIn;
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            wptr <= '0;
            rptr <= '0;
            cnt  <= '0;
        end else begin
            wptr <= wr ? wptr + AW'(1) : wptr;
            rptr <= pop ? rptr + AW'(1) : rptr;
            cnt  <= cnt + CW'(wr) - CW'(pop);
        end
    end

    assign bus.reqData  = mem[rptr];
    assign bus.reqEmpty = cnt == '0;
    assign bus.respTake = !reset && (is_req || rx_req);

`ifdef COPY_RESP_DROPCNT_EN
    logic [7:0] drops;
    always_ff @(posedge clock) begin
        if (reset) drops <= '0;
        else if (is_req && !accept && drops != 8'hff) drops <= drops + 8'd1;
    end
    assign bus.dropCount = drops;
`else
    assign bus.dropCount = 8'd0;
`endif

    always_ff @(posedge clock) begin
        if (reset) begin
            state  <= IDLE;
            dest_q <= '0;
            type_q <= '0;
            data_q <= '0;
        end else begin
            state <= state_next;
            if (state == IDLE && bus.replyValid && bus.replyDest != whichCore) begin
                dest_q <= bus.replyDest;
                type_q <= bus.replyType;
                data_q <= bus.replyData;
            end
        end
    end

    // loopback replies are handshaken but discarded, so IDLE stays put for them
    always_comb begin
        state_next = state;
        ring_out   = '0;
        drive      = 1'b0;
        wants      = 1'b0;
        ready      = 1'b0;
        case (state)
            IDLE: begin
                ready = 1'b1;
                if (bus.replyValid && bus.replyDest != whichCore) state_next = WAIT_TOKEN;
            end
            WAIT_TOKEN: begin
                wants = 1'b1;
                if (bus.respAcquireToken) begin
                    drive      = 1'b1;
                    ring_out   = {14'b0, dest_q, whichCore, type_q, 6'd1};
                    state_next = SEND;
                end
            end
            SEND: begin
                drive      = 1'b1;
                ring_out   = data_q;
                state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    assign bus.respRingOut     = ring_out;
    assign bus.respDriveRing   = drive;
    assign bus.respWantsToken  = wants;
    assign bus.replyReady      = ready;
    assign bus.respSlotTypeOut = 4'd8;
    assign bus.respSourceOut   = whichCore;
endmodule

// File: tb/tb_copy_responder.sv
// tb_copy_responder: randomized self-checking bench for copy_responder against a message-level queue model.
module tb_copy_responder;
    localparam int DEPTH = 32;

    logic       clock = 1'b0;
    logic       reset = 1'b1;
    logic [3:0] whichCore = 4'd15;
    int         errors = 0;
    int         checks = 0;
    int         exp_drops = 0;
    logic [31:0] q[$];

    copy_responder_if bus();

    copy_responder #(.RQ_DEPTH(DEPTH)) dut (
        .clock(clock),
        .reset(reset),
        .whichCore(whichCore),
        .bus(bus)
    );

    always #5 clock = ~clock;

    function automatic logic [31:0] hdr(input logic [3:0] d, input logic [3:0] s, input logic [3:0] t, input logic [5:0] l);
        return {14'b0, d, s, t, l};
    endfunction

    function automatic logic [7:0] drop_expect();
`ifdef COPY_RESP_DROPCNT_EN
        return exp_drops > 255 ? 8'd255 : 8'(exp_drops);
`else
        return 8'd0;
`endif
    endfunction

    task automatic send_msg(input logic [31:0] h, input int rd_pct);
        logic [31:0] w;
        logic        mine, acc;
        mine = h[17:14] == whichCore;
        acc  = mine && (DEPTH - q.size() >= int'(h[5:0]) + 1);
        if (mine && !acc) exp_drops++;
        for (int i = 0; i <= int'(h[5:0]); i++) begin
            w = (i == 0) ? h : $urandom;
            bus.RingIn     = w;
            bus.SlotTypeIn = (i == 0) ? 4'd8 : 4'($urandom_range(0, 15));
            bus.reqRead    = $urandom_range(0, 99) < rd_pct;
            #1;
            checks++;
            if (bus.respTake !== mine) begin
                errors++;
                $display("FAIL take word %0d of %h: got %b expected %b", i, h, bus.respTake, mine);
            end
            checks++;
            if (bus.reqEmpty !== (q.size() == 0)) begin
                errors++;
                $display("FAIL empty: got %b expected %b", bus.reqEmpty, q.size() == 0);
            end
            if (q.size() != 0) begin
                checks++;
                if (bus.reqData !== q[0]) begin
                    errors++;
                    $display("FAIL head: got %h expected %h", bus.reqData, q[0]);
                end
            end
            @(posedge clock);
            if (bus.reqRead && q.size() != 0) void'(q.pop_front());
            if (acc) q.push_back(w);
            #1;
        end
        bus.SlotTypeIn = 4'd0;
        bus.reqRead    = 1'b0;
    endtask

    task automatic drain();
        for (int i = 0; i < DEPTH + 2 && q.size() != 0; i++) begin
            bus.reqRead = 1'b1;
            #1;
            checks++;
            if (bus.reqEmpty !== 1'b0 || bus.reqData !== q[0]) begin
                errors++;
                $display("FAIL drain: got empty=%b data=%h expected data=%h", bus.reqEmpty, bus.reqData, q[0]);
            end
            @(posedge clock);
            void'(q.pop_front());
            #1;
        end
        bus.reqRead = 1'b0;
        #1;
        checks++;
        if (bus.reqEmpty !== 1'b1) begin
            errors++;
            $display("FAIL drained empty: got %b expected 1", bus.reqEmpty);
        end
        @(posedge clock);
        #1;
    endtask

    task automatic reply_seq(input logic [3:0] d, input logic [3:0] t, input logic [31:0] data, input int delay, input logic [31:0] exp_h);
        bus.replyValid = 1'b1;
        bus.replyDest  = d;
        bus.replyType  = t;
        bus.replyData  = data;
        #1;
        checks++;
        if (bus.replyReady !== 1'b1) begin
            errors++;
            $display("FAIL reply ready idle: got %b expected 1", bus.replyReady);
        end
        @(posedge clock);
        #1;
        bus.replyValid = 1'b0;
        bus.replyData  = ~data;
        for (int i = 0; i < delay; i++) begin
            bus.respAcquireToken = 1'b0;
            #1;
            checks++;
            if (bus.respWantsToken !== 1'b1 || bus.respDriveRing !== 1'b0 || bus.respRingOut !== 32'd0 || bus.replyReady !== 1'b0) begin
                errors++;
                $display("FAIL wait token: got wants=%b drive=%b ring=%h ready=%b expected 1 0 0 0",
                         bus.respWantsToken, bus.respDriveRing, bus.respRingOut, bus.replyReady);
            end
            @(posedge clock);
            #1;
        end
        bus.respAcquireToken = 1'b1;
        #1;
        checks++;
        if (bus.respDriveRing !== 1'b1 || bus.respRingOut !== exp_h) begin
            errors++;
            $display("FAIL reply header: got drive=%b ring=%h expected 1 %h", bus.respDriveRing, bus.respRingOut, exp_h);
        end
        @(posedge clock);
        #1;
        bus.respAcquireToken = 1'b0;
        #1;
        checks++;
        if (bus.respDriveRing !== 1'b1 || bus.respRingOut !== data || bus.respWantsToken !== 1'b0) begin
            errors++;
            $display("FAIL reply data: got drive=%b ring=%h wants=%b expected 1 %h 0",
                     bus.respDriveRing, bus.respRingOut, bus.respWantsToken, data);
        end
        @(posedge clock);
        #1;
        checks++;
        if (bus.replyReady !== 1'b1 || bus.respDriveRing !== 1'b0 || bus.respRingOut !== 32'd0) begin
            errors++;
            $display("FAIL reply idle: got ready=%b drive=%b ring=%h expected 1 0 0",
                     bus.replyReady, bus.respDriveRing, bus.respRingOut);
        end
        @(posedge clock);
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (2) @(posedge clock);
        #1;
        checks++;
        if (bus.reqEmpty !== 1'b1 || bus.respWantsToken !== 1'b0 || bus.respDriveRing !== 1'b0 ||
            bus.respTake !== 1'b0 || bus.replyReady !== 1'b1 || bus.dropCount !== 8'd0 || bus.respRingOut !== 32'd0) begin
            errors++;
            $display("FAIL reset: got empty=%b wants=%b drive=%b take=%b ready=%b drops=%0d ring=%h",
                     bus.reqEmpty, bus.respWantsToken, bus.respDriveRing, bus.respTake,
                     bus.replyReady, bus.dropCount, bus.respRingOut);
        end
        checks++;
        if (bus.respSlotTypeOut !== 4'd8 || bus.respSourceOut !== whichCore) begin
            errors++;
            $display("FAIL constants: got slot=%h src=%h expected 8 %h", bus.respSlotTypeOut, bus.respSourceOut, whichCore);
        end
        reset = 1'b0;
        @(posedge clock);
        #1;
    endtask

    task automatic test_single_request();
        send_msg(32'h0003_C403, 0);
        checks++;
        if (bus.reqEmpty !== 1'b0 || bus.reqData !== 32'h0003_C403) begin
            errors++;
            $display("FAIL single head: got empty=%b data=%h expected 0 0003c403", bus.reqEmpty, bus.reqData);
        end
        drain();
    endtask

    task automatic test_foreign();
        send_msg(hdr(4'd2, 4'd7, 4'd1, 6'd5), 0);
        send_msg(32'h0003_C403, 0);
        drain();
    endtask

    task automatic test_reply();
        reply_seq(4'd1, 4'd0, 32'hDEAD_BEEF, 3, 32'h0000_7C01);
        bus.replyValid = 1'b1;
        bus.replyDest  = whichCore;
        #1;
        @(posedge clock);
        #1;
        bus.replyValid = 1'b0;
        #1;
        checks++;
        if (bus.replyReady !== 1'b1 || bus.respWantsToken !== 1'b0) begin
            errors++;
            $display("FAIL loopback: got ready=%b wants=%b expected 1 0", bus.replyReady, bus.respWantsToken);
        end
        @(posedge clock);
        #1;
    endtask

    task automatic test_overflow();
        for (int i = 0; i < 3; i++) send_msg(hdr(4'd15, 4'(i), 4'd0, 6'd9), 0);
        send_msg(hdr(4'd15, 4'd2, 4'd0, 6'd3), 0);
        checks++;
        if (bus.dropCount !== drop_expect()) begin
            errors++;
            $display("FAIL overflow drops: got %0d expected %0d", bus.dropCount, drop_expect());
        end
        send_msg(hdr(4'd15, 4'd3, 4'd0, 6'd1), 0);
        for (int i = 0; i < 260; i++) send_msg(hdr(4'd15, 4'd4, 4'd1, 6'd0), 0);
        checks++;
        if (bus.dropCount !== drop_expect()) begin
            errors++;
            $display("FAIL saturate drops: got %0d expected %0d", bus.dropCount, drop_expect());
        end
        drain();
    endtask

    task automatic test_concurrent();
        fork
            send_msg(hdr(4'd15, 4'd4, 4'd1, 6'd6), 30);
            reply_seq(4'd5, 4'd2, $urandom, 2, hdr(4'd5, whichCore, 4'd2, 6'd1));
        join
        drain();
    endtask

    task automatic test_reset_mid();
        bus.replyValid = 1'b1;
        bus.replyDest  = 4'd3;
        bus.RingIn     = hdr(4'd15, 4'd1, 4'd2, 6'd5);
        bus.SlotTypeIn = 4'd8;
        @(posedge clock);
        #1;
        bus.replyValid = 1'b0;
        for (int i = 0; i < 2; i++) begin
            bus.RingIn     = $urandom;
            bus.SlotTypeIn = 4'd0;
            @(posedge clock);
            #1;
        end
        reset = 1'b1;
        bus.respAcquireToken = 1'b1;
        @(posedge clock);
        #1;
        reset = 1'b0;
        bus.respAcquireToken = 1'b0;
        q.delete();
        exp_drops = 0;
        #1;
        checks++;
        if (bus.respWantsToken !== 1'b0 || bus.reqEmpty !== 1'b1 || bus.replyReady !== 1'b1 ||
            bus.respDriveRing !== 1'b0 || bus.respTake !== 1'b0 || bus.dropCount !== 8'd0) begin
            errors++;
            $display("FAIL reset mid-op: got wants=%b empty=%b ready=%b drive=%b take=%b drops=%0d",
                     bus.respWantsToken, bus.reqEmpty, bus.replyReady, bus.respDriveRing, bus.respTake, bus.dropCount);
        end
        send_msg(hdr(4'd15, 4'd6, 4'd3, 6'd2), 0);
        drain();
    endtask

    task automatic test_random();
        logic [3:0] d;
        for (int n = 0; n < 60; n++) begin
            d = ($urandom_range(0, 2) != 0) ? whichCore : 4'($urandom_range(0, 14));
            send_msg(hdr(d, 4'($urandom), 4'($urandom), 6'($urandom_range(0, 12))), $urandom_range(0, 60));
            for (int i = $urandom_range(0, 2); i > 0; i--) begin
                bus.RingIn = $urandom;
                @(posedge clock);
                #1;
            end
        end
        checks++;
        if (bus.dropCount !== drop_expect()) begin
            errors++;
            $display("FAIL random drops: got %0d expected %0d", bus.dropCount, drop_expect());
        end
        drain();
    endtask

    initial begin
        bus.RingIn           = '0;
        bus.SlotTypeIn       = '0;
        bus.SourceIn         = '0;
        bus.respAcquireToken = 1'b0;
        bus.reqRead          = 1'b0;
        bus.replyValid       = 1'b0;
        bus.replyDest        = '0;
        bus.replyType        = '0;
        bus.replyData        = '0;
        test_reset();
        test_single_request();
        test_foreign();
        test_reply();
        test_overflow();
        test_concurrent();
        test_reset_mid();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/copy_responder.md
COPY_RESPONDER -- requirements
Module: copy_responder

Interface
REQ-001 SHALL have parameter RQ_DEPTH, default 32, request FIFO depth in words (power of 2, at least 8).
REQ-002 SHALL have ports clock in 1 (sole clock) and reset in 1 (synchronous, active-high); one clock, no other clock domains.
REQ-003 SHALL have port whichCore in 4, this block's core number, which is the copier's core number.
REQ-004 SHALL have ring inputs RingIn in 32, SlotTypeIn in 4 and SourceIn in 4.
REQ-005 SHALL have ring outputs respRingOut out 32, respSlotTypeOut out 4, respSourceOut out 4, respDriveRing out 1, respWantsToken out 1, respAcquireToken in 1, and respTake out 1 (request that the ring station null the current slot).
REQ-006 SHALL have engine request ports reqData out 32, reqEmpty out 1 and reqRead in 1, forming a first-word-fall-through FIFO read port.
REQ-007 SHALL have engine reply ports replyValid in 1, replyReady out 1, replyDest in 4, replyType in 4 and replyData in 32.
REQ-008 SHALL have port dropCount out 8, a saturating count of discarded requests.

Function
REQ-009 SHALL track ring messages with a 6-bit inLen counter, as follows.
- Counter: when inLen != 0 it decrements every cycle.
- Header condition: inLen == 0 and SlotTypeIn == 8 (Message).
- Header load: on a header, inLen <= RingIn[5:0], for all destinations.
REQ-010 SHALL treat a header with RingIn[17:14] == whichCore as a request; header fields are src [13:10], type [9:6], len [5:0].
REQ-011 SHALL write an accepted request's header word and all len payload words into the request FIFO, one word per cycle, with respTake asserted on each of those cycles.
REQ-012 SHALL accept a request only if FIFO free space is at least len+1 at header time.
- Otherwise: the whole message is consumed (respTake still asserted), nothing is written, and dropCount is incremented.
- The drop is decided once, at the header; no partial message is ever written.
REQ-013 SHALL write only the header word for a zero-length request.
REQ-014 SHALL present reqData as the head word while reqEmpty is 0; reqRead pops the head.
- reqRead while empty is ignored.
- A simultaneous write and pop in the same cycle both take effect.
REQ-015 SHALL drive replyReady = 1 only in state IDLE.
- On replyValid & replyReady: latch replyDest, replyType and replyData, then go to WAIT_TOKEN.
REQ-016 SHALL use reply state machine states IDLE, WAIT_TOKEN and SEND.
- IDLE -> WAIT_TOKEN on an accepted reply.
- WAIT_TOKEN -> SEND on respAcquireToken.
- SEND -> IDLE unconditionally after one cycle.
REQ-017 SHALL assert respWantsToken exactly in WAIT_TOKEN.
REQ-018 SHALL drive the ring with the reply header in the respAcquireToken cycle of WAIT_TOKEN.
- Header value: {14'b0, latched dest, whichCore, latched type, 6'd1}.
- respDriveRing = 1 in that cycle.
REQ-019 SHALL drive latched replyData with respDriveRing = 1 in SEND.
REQ-020 SHALL hold respSlotTypeOut = 8 and respSourceOut = whichCore constantly; respRingOut = 0 whenever not driving.
REQ-021 SHALL keep request reception independent of reply transmission, including simultaneous receive and send.
REQ-022 SHALL ignore a reply with replyDest == whichCore (no loopback): replyReady stays 1 and the state is unchanged.

Reset
REQ-023 SHALL on reset set the following:
- state = IDLE and inLen = 0;
- FIFO empty (reqEmpty = 1), dropCount = 0;
- respDriveRing = 0, respWantsToken = 0, respTake = 0, replyReady = 1.
REQ-024 SHALL abort any in-progress receive or send on reset mid-operation, with no further ring drive from the next cycle.
- The partially written request is discarded with the FIFO reset.

Configuration
REQ-025 SHALL implement the drop-count feature only when macro COPY_RESP_DROPCNT_EN is defined.
- With the macro: dropCount counts dropped requests and saturates at 255.
- Without the macro: dropCount is tied to 0 and drops are silent; all other behaviour is identical.

Verification
REQ-026 SHALL cover a single request: header 0x0003_C403 (dest 15, src 1, type 0, len 3) plus 3 payload words, whichCore = 15.
- Expected: 4 FIFO words in order and respTake asserted for 4 cycles.
REQ-027 SHALL cover a foreign message: header dest 2, len 5.
- Expected: no FIFO writes and no respTake; the next header at cycle +6 is decoded correctly.
REQ-028 SHALL cover a reply: replyDest = 1, replyType = 0, replyData = 0xDEADBEEF, with the token granted after 3 cycles.
- Expected: header 0x0000_7C01 then 0xDEADBEEF on consecutive cycles, then IDLE.
REQ-029 SHALL cover overflow: with 30 of 32 words occupied, a len-3 request arrives.
- Expected: request dropped, dropCount = 1 and FIFO unchanged; a len-1 request afterwards is accepted.
REQ-030 SHALL cover reset in WAIT_TOKEN and reset mid-payload.
- Expected: respWantsToken = 0, reqEmpty = 1, replyReady = 1 the next cycle.
